// File: rtl/fp_minmax_reduce.sv
// Streaming min/max reduction over IEEE-754-style floats.
// Accepts one element per cycle, framed by in_last, and returns the extreme
// value, its zero-based index and a sticky NaN flag. Once a vector contains
// a NaN, the value reported is the canonical quiet NaN, and its index is the
// index of the first NaN in the vector.
module fp_minmax_reduce #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23,
    parameter int unsigned IDX_W = 16,
    localparam int unsigned W = 1 + EXP_W + MAN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [IDX_W-1:0] out_index,
    output logic             out_nan
);

    typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

    localparam logic [W-1:0] QNan = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    state_e           state_q, state_d;
    logic [W-1:0]     acc_q, acc_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             nan_q, nan_d;
    logic             mode_q, mode_d;

    logic             accept;
    logic             in_nan;
    logic [W-1:0]     key_in;
    logic [W-1:0]     key_acc;
    logic             new_wins;

    // NaN: exponent all ones with a non-zero mantissa (infinity is not a NaN).
    function automatic logic is_nan(input logic [W-1:0] v);
        return (&v[W-2:MAN_W]) && (|v[MAN_W-1:0]);
    endfunction

    // Monotonic order key: positives above negatives, negatives reversed so
    // that larger magnitudes sort lower. Gives -0 < +0 and orders denormals.
    function automatic logic [W-1:0] order_key(input logic [W-1:0] v);
        return v[W-1] ? {1'b0, ~v[W-2:0]} : {1'b1, v[W-2:0]};
    endfunction

    // Handshake and comparison terms.
    always_comb begin
        in_ready  = (state_q != StDone);
        out_valid = (state_q == StDone);
        accept    = in_valid & in_ready;
        in_nan    = is_nan(in_data);
        key_in    = order_key(in_data);
        key_acc   = order_key(acc_q);
        // Strict compare: equal keys keep the earlier element.
        new_wins  = mode_q ? (key_in > key_acc) : (key_in < key_acc);
    end

    // Next-state and accumulator update.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        nan_d   = nan_q;
        mode_d  = mode_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    acc_d   = in_data;
                    idx_d   = '0;
                    cnt_d   = IDX_W'(1);
                    mode_d  = mode;
                    nan_d   = in_nan;
                    state_d = in_last ? StDone : StAccum;
                end
            end
            StAccum: begin
                if (accept) begin
                    // A seen NaN freezes value and index for the rest of the vector.
                    if (!nan_q && (in_nan || new_wins)) begin
                        acc_d = in_data;
                        idx_d = cnt_q;
                    end
                    cnt_d   = cnt_q + IDX_W'(1);
                    nan_d   = nan_q | in_nan;
                    state_d = in_last ? StDone : StAccum;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and accumulator registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            nan_q   <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            nan_q   <= nan_d;
            mode_q  <= mode_d;
        end
    end

    // Result is driven straight from registers; NaN vectors report the canonical qNaN.
    always_comb begin
        out_data  = nan_q ? QNan : acc_q;
        out_index = idx_q;
        out_nan   = nan_q;
    end

endmodule

// File: doc/fp_minmax_reduce.md
Name: fp_minmax_reduce

Overview:
- Streaming min/max reduction unit for parametrised IEEE-754-style floats.
- Accepts one element per cycle over a valid/ready stream, framed by in_last.
- Returns the extreme value of the vector, the index of that value, and a NaN flag.
- Sits after the vector datapath; serves max-pool/argmax style reductions.
- Successor to the combinational two-operand min: parametrised format, runtime min/max mode, sequential accumulation, denormal/zero/NaN handling, argmin/argmax index output.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored mantissa field width. Word width W = 1+EXP_W+MAN_W.
- IDX_W, 16, element index counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  1  0 = min, 1 = max; sampled only with the first element of a vector.
- in_valid  in  1  input element valid.
- in_ready  out  1  unit can accept an element.
- in_data  in  W  element {sign, exponent, mantissa}.
- in_last  in  1  marks the final element of the vector.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  W  reduced value.
- out_index  out  IDX_W  zero-based position of the result element in the vector.
- out_nan  out  1  at least one element of the vector was NaN.

Behaviour:
- Reset (async, rst_n low): state = IDLE; out_valid = 0, out_data = 0, out_index = 0, out_nan = 0; accumulator and counter = 0. Reset mid-vector discards the partial vector.
- States: IDLE, ACCUM, DONE.
  - in_ready = 1 in IDLE and ACCUM; in_ready = 0 in DONE.
  - out_valid = 1 only in DONE.
- Accept = in_valid & in_ready.
- IDLE + accept:
  - load accumulator with in_data, best index = 0, count = 1, latch mode.
  - nan_seen = NaN(in_data).
  - Next state: DONE if in_last, else ACCUM.
- ACCUM + accept:
  - compare in_data against accumulator; replace value and index (= count) when the new element wins.
  - count++, update nan_seen.
  - Next state: DONE if in_last, else ACCUM.
- DONE: out_* hold stable until out_ready; on out_valid & out_ready go to IDLE. in_ready rises the following cycle.
- Latency: the result is registered; out_valid asserts the cycle after the in_last element is accepted. Single-element vector: out_valid the cycle after acceptance, index 0.
- Throughput: 1 element/cycle inside a vector; one bubble cycle minimum between vectors (the DONE cycle).
- Ordering:
  - Compare via order key: positive -> {1, magnitude}, negative -> {0, ~magnitude}. Unsigned compare of keys, no normalisation.
  - Denormals and infinities order correctly under this key.
  - -0 < +0.
- Ties (equal keys): keep the earlier element; index is not updated.
- NaN (exponent all ones, mantissa != 0):
  - The first NaN wins and freezes the accumulator and index for the rest of the vector.
  - out_data = canonical quiet NaN {0, all-ones exponent, 1 followed by MAN_W-1 zeros}.
  - out_nan = 1; out_index = index of the first NaN.
- mode changes after the first element are ignored until the next vector.
- Index counter wraps modulo 2^IDX_W. Vectors longer than 2^IDX_W report a wrapped index; no error flag.
- in_data/in_last are ignored when in_valid = 0. in_valid may drop mid-vector; state holds.

Test Plan:
- mode=0, vector {0x40400000, 0xBFC00000, 0x40000000} -> out_data 0xBFC00000, out_index 1, out_nan 0, out_valid one cycle after the third accept.
- mode=1, same vector -> out_data 0x40400000, out_index 0.
- mode=0, {0x00000000, 0x80000000, 0x00000001} -> 0x80000000, index 1. mode=1 -> 0x00000001 (denormal), index 2.
- mode=1, {0x7F800000, 0x7F800000, 0x3F800000} -> 0x7F800000, index 0 (tie keeps earliest).
- mode=0, {0x3F800000, 0x7FA00000, 0xFF800000} -> out_data 0x7FC00000, out_nan 1, index 1.
- Hold out_ready=0 for 5 cycles -> out_* stable and in_ready=0. Assert rst_n low mid-vector -> out_valid 0 immediately. A fresh single-element vector {0x3F800000} -> result 0x3F800000, index 0.
